// File: rtl/key_schedule_iter.sv
// key_schedule_iter: iterative AES key expansion, one 32-bit word per clock.
// Stores the whole schedule and serves 128-bit round keys through a
// registered read port. A single shared 4-byte S-box does every SubWord.
// Optional build macro KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input and a
// ZERO state that wipes the stored schedule one word per cycle.
module key_schedule_iter #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
  input  logic              zeroize,
`endif
  input  logic              start,
  input  logic [NK*32-1:0]  key_in,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk_out,
  output logic              rk_valid
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);
  localparam int CW    = 6;

  localparam logic [CW-1:0] LAST_W  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] NK_W    = CW'(NK);
  localparam logic [2:0]    NK_LAST = 3'(NK - 1);
  localparam logic [3:0]    NR_IDX  = 4'(NR);

  // Only AES-128/192/256 key lengths are meaningful.
  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_schedule_iter: NK must be 4, 6 or 8");
  end

`ifdef KEY_SCHEDULE_ZEROIZE_EN
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE, S_ZERO} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;
`endif

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     phase_reg;     // c mod NK, tracked incrementally
  logic [7:0]     rcon_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           valid_reg;
  logic [127:0]   rk_out_reg;

  logic [31:0]    mem [0:TOTAL-1];
  logic [31:0]    win_reg [0:NK-1];  // last NK words: [0] = w[c-NK], [NK-1] = w[c-1]
  logic [31:0]    key_word [0:NK-1];
  logic [31:0]    rd_word [0:3];

  logic           zero_req;
  logic           load_key;
  logic           expand_step;
  logic           zero_step;
  logic [31:0]    prev_word;
  logic [31:0]    old_word;
  logic [31:0]    sbox_in;
  logic [31:0]    sub_word;
  logic [31:0]    f_word;
  logic [31:0]    new_word;
  logic           idx_ok;
  logic [3:0]     rd_base;

  // GF(2^8) multiply, polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box computed as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef KEY_SCHEDULE_ZEROIZE_EN
  assign zero_req  = zeroize && (state_reg != S_ZERO);
  assign zero_step = (state_reg == S_ZERO);
`else
  assign zero_req  = 1'b0;
  assign zero_step = 1'b0;
`endif

  assign load_key    = (state_reg == S_IDLE) && start && !zero_req;
  assign expand_step = (state_reg == S_EXPAND) && !zero_req;

  assign prev_word = win_reg[NK-1];
  assign old_word  = win_reg[0];
  assign sbox_in   = (phase_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  // Key words in FIPS-197 order: word 0 is the most significant.
  for (genvar gi = 0; gi < NK; gi++) begin : g_key
    assign key_word[gi] = key_in[NK*32-1-32*gi -: 32];
  end

  // The one shared 4-byte S-box.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_word[8*gi +: 8] = sbox(sbox_in[8*gi +: 8]);
  end

  // Select the recurrence term f for the word being produced.
  always_comb begin
    f_word = prev_word;
    if (phase_reg == 3'd0) begin
      f_word = sub_word ^ {rcon_reg, 24'h000000};
    end else if (NK == 8 && phase_reg == 3'd4) begin
      f_word = sub_word;
    end
  end

  assign new_word = old_word ^ f_word;

  // Schedule storage and sliding window; contents are never observable unless valid.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int i = 0; i < NK; i++) begin
        mem[i]     <= key_word[i];
        win_reg[i] <= key_word[i];
      end
    end else if (expand_step) begin
      mem[cnt_reg] <= new_word;
      for (int i = 0; i < NK - 1; i++) begin
        win_reg[i] <= win_reg[i+1];
      end
      win_reg[NK-1] <= new_word;
    end else if (zero_step) begin
      mem[cnt_reg] <= 32'h0;
      for (int i = 0; i < NK; i++) begin
        win_reg[i] <= 32'h0;
      end
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      phase_reg <= 3'd0;
      rcon_reg  <= 8'h01;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
      if (zero_req) begin
        state_reg <= S_ZERO;
        cnt_reg   <= '0;
        busy_reg  <= 1'b1;
        valid_reg <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              state_reg <= S_EXPAND;
              cnt_reg   <= NK_W;
              phase_reg <= 3'd0;
              rcon_reg  <= 8'h01;
              busy_reg  <= 1'b1;
              valid_reg <= 1'b0;
            end
          end
          S_EXPAND: begin
            cnt_reg   <= cnt_reg + 1'b1;
            phase_reg <= (phase_reg == NK_LAST) ? 3'd0 : phase_reg + 3'd1;
            if (phase_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
            if (cnt_reg == LAST_W) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
            end
          end
          S_DONE: begin
            done_reg  <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
`ifdef KEY_SCHEDULE_ZEROIZE_EN
          S_ZERO: begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_W) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
              cnt_reg   <= '0;
            end
          end
`endif
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Out-of-range indices read word group 0 internally but return zero.
  assign idx_ok  = (rk_idx <= NR_IDX);
  assign rd_base = idx_ok ? rk_idx : 4'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    assign rd_word[gi] = mem[{rd_base, 2'b00} + CW'(gi)];
  end

  // Registered round-key read, one cycle after rk_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_reg <= '0;
    end else begin
      rk_out_reg <= idx_ok ? {rd_word[0], rd_word[1], rd_word[2], rd_word[3]} : 128'h0;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rk_valid = valid_reg;
  // Gating by valid keeps a stale or partial schedule from ever appearing.
  assign rk_out   = valid_reg ? rk_out_reg : 128'h0;

endmodule
